// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the dmem arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int BURST_W      = 4;
  localparam int STARVE_LIMIT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam logic PHYS = 1'b0;
  localparam logic VGA  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, processor and dmem-side signals around the arbiter.
// slave = arbiter view, master = requesters/dmem view.
interface dmem_arbiter_if #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
);

  logic              proc_en;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_wren;
  logic [DATA_W-1:0] proc_rdata;
  logic              proc_stall;

  logic               phys_req;
  logic [ADDR_W-1:0]  phys_addr;
  logic [BURST_W-1:0] phys_len;
  logic               phys_wren;
  logic [DATA_W-1:0]  phys_wdata;
  logic               phys_gnt;
  logic               phys_rvalid;
  logic [DATA_W-1:0]  phys_rdata;
  logic               phys_done;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  proc_en, proc_addr, proc_wdata, proc_wren,
    output proc_rdata, proc_stall,
    input  phys_req, phys_addr, phys_len, phys_wren, phys_wdata,
    output phys_gnt, phys_rvalid, phys_rdata, phys_done,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    output address_dmem, data, wren,
    input  q_dmem
  );

  modport master (
    output proc_en, proc_addr, proc_wdata, proc_wren,
    input  proc_rdata, proc_stall,
    output phys_req, phys_addr, phys_len, phys_wren, phys_wdata,
    input  phys_gnt, phys_rvalid, phys_rdata, phys_done,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  address_dmem, data, wren,
    output q_dmem
  );

endinterface

// File: rtl/dmem_arb_burst_ctr.sv
// Physics burst tracker: latches direction, walks the beat address (wrapping)
// and down-counts the beats still to issue after the current one.
module dmem_arb_burst_ctr #(
  parameter int ADDR_W  = 12,
  parameter int BURST_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               adv_i,
  input  logic [ADDR_W-1:0]  base_i,
  input  logic [BURST_W-1:0] len_i,
  input  logic               dir_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               dir_o,
  output logic               last_o
);

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               dir_q, dir_d;

  // Beat 0 issues straight from the request, so the latch starts at beat 1.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    dir_d  = dir_q;
    if (load_i) begin
      addr_d = base_i + ADDR_W'(1);
      rem_d  = len_i - BURST_W'(1);
      dir_d  = dir_i;
    end else if (adv_i) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - BURST_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      dir_q  <= dir_d;
    end
  end

  assign addr_o = addr_q;
  assign dir_o  = dir_q;
  assign last_o = (rem_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: processor pass-through first, then physics bursts
// and VGA reads round-robin. Starvation guard under DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W       = dmem_arb_pkg::DATA_W,
`ifdef DMEM_ARB_STARVE_GUARD_EN
  parameter int STARVE_LIMIT = dmem_arb_pkg::STARVE_LIMIT,
`endif
  parameter int BURST_W      = dmem_arb_pkg::BURST_W
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  import dmem_arb_pkg::*;

  // state | meaning
  // IDLE  | no burst open; free cycles go to PHYS/VGA by rr_q
  // BURST | physics burst open; free cycles issue its next beat

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic              done_q, done_d;
  logic              phys_rv_q, phys_rv_d;
  logic [DATA_W-1:0] phys_rdata_q, phys_rdata_d;
  logic              vga_rv_q, vga_rv_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

  logic              stall, proc_own, free, sec_wait;
  logic              gnt_phys, gnt_vga, ctr_load, ctr_adv;
  logic [ADDR_W-1:0] ctr_addr;
  logic              ctr_dir, ctr_last;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              wren_mux;

  assign sec_wait = (state_q == BURST) || bus.phys_req || bus.vga_req;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign stall = reset && sec_wait && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (gnt_phys || gnt_vga)
      starve_d = '0;
    else if (proc_own && sec_wait && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    proc_own = reset && bus.proc_en && !stall;
    free     = reset && !proc_own;
    gnt_phys = 1'b0;
    gnt_vga  = 1'b0;
    ctr_load = 1'b0;
    ctr_adv  = 1'b0;
    state_d  = state_q;
    rr_d     = rr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (free) begin
        if (bus.phys_req && (!bus.vga_req || rr_q == PHYS)) gnt_phys = 1'b1;
        else if (bus.vga_req)                                gnt_vga  = 1'b1;
        if (bus.phys_req && bus.vga_req) rr_d = gnt_phys ? VGA : PHYS;
        if (gnt_phys) begin
          ctr_load = 1'b1;
          if (bus.phys_len == '0) done_d  = 1'b1;
          else                    state_d = BURST;
        end
      end
      BURST: if (free) begin
        gnt_phys = 1'b1;
        ctr_adv  = 1'b1;
        if (ctr_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write data is only driven on write cycles; reads present zero.
  always_comb begin
    addr_mux = '0;
    data_mux = '0;
    wren_mux = 1'b0;
    if (proc_own) begin
      addr_mux = bus.proc_addr;
      wren_mux = bus.proc_wren;
      data_mux = bus.proc_wren ? bus.proc_wdata : '0;
    end else if (gnt_phys && state_q == IDLE) begin
      addr_mux = bus.phys_addr;
      wren_mux = bus.phys_wren;
      data_mux = bus.phys_wren ? bus.phys_wdata : '0;
    end else if (gnt_phys) begin
      addr_mux = ctr_addr;
      wren_mux = ctr_dir;
      data_mux = ctr_dir ? bus.phys_wdata : '0;
    end else if (gnt_vga) begin
      addr_mux = bus.vga_addr;
    end
  end

  always_comb begin
    phys_rv_d    = gnt_phys && !wren_mux;
    phys_rdata_d = phys_rv_d ? bus.q_dmem : phys_rdata_q;
    vga_rv_d     = gnt_vga;
    vga_rdata_d  = gnt_vga ? bus.q_dmem : vga_rdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= PHYS;
      done_q       <= 1'b0;
      phys_rv_q    <= 1'b0;
      phys_rdata_q <= '0;
      vga_rv_q     <= 1'b0;
      vga_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      done_q       <= done_d;
      phys_rv_q    <= phys_rv_d;
      phys_rdata_q <= phys_rdata_d;
      vga_rv_q     <= vga_rv_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  dmem_arb_burst_ctr #(
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) u_burst_ctr (
    .clock  (clock),
    .reset  (reset),
    .load_i (ctr_load),
    .adv_i  (ctr_adv),
    .base_i (bus.phys_addr),
    .len_i  (bus.phys_len),
    .dir_i  (bus.phys_wren),
    .addr_o (ctr_addr),
    .dir_o  (ctr_dir),
    .last_o (ctr_last)
  );

  assign bus.proc_rdata   = bus.q_dmem;
  assign bus.proc_stall   = stall;
  assign bus.phys_gnt     = gnt_phys;
  assign bus.phys_rvalid  = phys_rv_q;
  assign bus.phys_rdata   = phys_rdata_q;
  assign bus.phys_done    = done_q;
  assign bus.vga_gnt      = gnt_vga;
  assign bus.vga_rvalid   = vga_rv_q;
  assign bus.vga_rdata    = vga_rdata_q;
  assign bus.address_dmem = addr_mux;
  assign bus.data         = data_mux;
  assign bus.wren         = wren_mux;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: negedge-clocked dmem model, per-cycle reference model
// of the arbitration rules, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BURST_W(4)) bus ();

  dmem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h100) ? 32'h12345678 : (32'hA500_0000 | {20'd0, a});
  endfunction

  // dmem: registered on the falling edge, write-through on q
  bit [31:0]   mem    [4096];
  bit          mem_v  [4096];
  logic [31:0] q_r = '0;
  always @(negedge clock) begin
    if (bus.wren) begin
      mem[bus.address_dmem]   <= bus.data;
      mem_v[bus.address_dmem] <= 1'b1;
      q_r <= bus.data;
    end else begin
      q_r <= mem_v[bus.address_dmem] ? mem[bus.address_dmem] : init_word(bus.address_dmem);
    end
  end
  assign bus.q_dmem = q_r;

  function automatic logic [31:0] mem_rd(input logic [11:0] a);
    return mem_v[a] ? mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
    #2;
  endtask

  // ---------------- reference model ----------------
  bit [31:0]   ref_mem [4096];
  bit          ref_v   [4096];
  bit          m_burst, m_rr, m_dir, m_done, m_prv, m_vrv;
  logic [31:0] m_prd, m_vrd;
  int          m_base, m_k, m_len, m_starve;
  bit          p_own, stall_e, waiting, eg_p, eg_v, e_wren, done_n;
  logic [11:0] e_addr;
  logic [31:0] e_data, e_rd;

  always begin
    samp();
    if (!reset) begin
      chk("rst_addr", {20'd0, bus.address_dmem}, 32'd0);
      chk("rst_data", bus.data, 32'd0);
      chk("rst_ctl", {23'd0, bus.wren, bus.phys_gnt, bus.vga_gnt, bus.proc_stall,
                      bus.phys_rvalid, bus.vga_rvalid, bus.phys_done, 2'b00}, 32'd0);
      chk("rst_phys_rdata", bus.phys_rdata, 32'd0);
      chk("rst_vga_rdata", bus.vga_rdata, 32'd0);
      m_burst = 0; m_rr = 0; m_dir = 0; m_done = 0; m_prv = 0; m_vrv = 0;
      m_prd = '0; m_vrd = '0; m_k = 0; m_len = 0; m_base = 0; m_starve = 0;
    end else begin
      waiting = m_burst || bus.phys_req || bus.vga_req;
      stall_e = 1'b0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      stall_e = (m_starve >= 8) && waiting;
`endif
      p_own = bus.proc_en && !stall_e;
      eg_p = 0; eg_v = 0; e_addr = '0; e_data = '0; e_wren = 0; done_n = 0;
      if (p_own) begin
        e_addr = bus.proc_addr; e_wren = bus.proc_wren;
        e_data = bus.proc_wren ? bus.proc_wdata : 32'd0;
      end else if (m_burst) begin
        eg_p = 1; e_addr = 12'((m_base + m_k) % 4096); e_wren = m_dir;
        e_data = m_dir ? bus.phys_wdata : 32'd0;
      end else if (bus.phys_req && (!bus.vga_req || m_rr == 0)) begin
        eg_p = 1; e_addr = bus.phys_addr; e_wren = bus.phys_wren;
        e_data = bus.phys_wren ? bus.phys_wdata : 32'd0;
      end else if (bus.vga_req) begin
        eg_v = 1; e_addr = bus.vga_addr;
      end
      chk("address_dmem", {20'd0, bus.address_dmem}, {20'd0, e_addr});
      chk("data", bus.data, e_data);
      chk("wren", {31'd0, bus.wren}, {31'd0, e_wren});
      chk("phys_gnt", {31'd0, bus.phys_gnt}, {31'd0, eg_p});
      chk("vga_gnt", {31'd0, bus.vga_gnt}, {31'd0, eg_v});
      chk("proc_stall", {31'd0, bus.proc_stall}, {31'd0, stall_e});
      chk("phys_rvalid", {31'd0, bus.phys_rvalid}, {31'd0, m_prv});
      chk("phys_rdata", bus.phys_rdata, m_prd);
      chk("vga_rvalid", {31'd0, bus.vga_rvalid}, {31'd0, m_vrv});
      chk("vga_rdata", bus.vga_rdata, m_vrd);
      chk("phys_done", {31'd0, bus.phys_done}, {31'd0, m_done});
      e_rd = ref_v[e_addr] ? ref_mem[e_addr] : init_word(e_addr);
      if (p_own && !e_wren) chk("proc_rdata", bus.proc_rdata, e_rd);
      if (e_wren) begin ref_mem[e_addr] = e_data; ref_v[e_addr] = 1; end
      // advance model state to the next cycle
      if (!p_own && !m_burst && bus.phys_req && bus.vga_req) m_rr = eg_p;
      if (eg_p && !m_burst) begin
        if (bus.phys_len == 0) done_n = 1;
        else begin
          m_burst = 1; m_base = int'(bus.phys_addr); m_len = int'(bus.phys_len);
          m_k = 1; m_dir = bus.phys_wren;
        end
      end else if (eg_p) begin
        if (m_k == m_len) begin m_burst = 0; done_n = 1; end
        else m_k++;
      end
      m_prv = eg_p && !e_wren;
      if (m_prv) m_prd = e_rd;
      m_vrv = eg_v;
      if (eg_v) m_vrd = e_rd;
      if (eg_p || eg_v) m_starve = 0;
      else if (p_own && waiting && m_starve < 8) m_starve++;
      m_done = done_n;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [11:0] beat_addr [8];
  logic [31:0] rd_data   [8];
  int n_beats, n_rv, last_c, done_c, n_done;

  task automatic idle_inputs();
    bus.proc_en = 0; bus.proc_addr = '0; bus.proc_wdata = '0; bus.proc_wren = 0;
    bus.phys_req = 0; bus.phys_addr = '0; bus.phys_len = '0; bus.phys_wren = 0;
    bus.phys_wdata = '0; bus.vga_req = 0; bus.vga_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 0;
    bus.proc_en = 1; bus.proc_addr = 12'h123; bus.proc_wren = 1;
    bus.proc_wdata = 32'hFFFF_FFFF; bus.vga_req = 1; bus.vga_addr = 12'h055;
    samp();
    chk("reset_gates_addr", {20'd0, bus.address_dmem}, 32'd0);
    chk("reset_gates_wren", {31'd0, bus.wren}, 32'd0);
    tick(); idle_inputs();
    tick(); reset = 1;

    // processor write then read
    bus.proc_en = 1; bus.proc_wren = 1; bus.proc_addr = 12'h010; bus.proc_wdata = 32'hDEADBEEF;
    samp();
    chk("proc_wr_addr", {20'd0, bus.address_dmem}, 32'h010);
    chk("proc_wr_wren", {31'd0, bus.wren}, 32'd1);
    chk("proc_wr_nognt", {30'd0, bus.phys_gnt, bus.vga_gnt}, 32'd0);
    tick(); bus.proc_wren = 0;
    samp();
    chk("proc_rd_data", bus.proc_rdata, 32'hDEADBEEF);
    tick(); idle_inputs();

    // VGA single read
    bus.vga_req = 1; bus.vga_addr = 12'h100;
    samp();
    chk("vga_gnt_same_cycle", {31'd0, bus.vga_gnt}, 32'd1);
    tick(); bus.vga_req = 0;
    samp();
    chk("vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd1);
    chk("vga_rdata", bus.vga_rdata, 32'h12345678);
    tick();

    // physics write burst with address wrap
    bus.phys_req = 1; bus.phys_addr = 12'hFFE; bus.phys_len = 4'd3; bus.phys_wren = 1;
    bus.phys_wdata = 32'h0000_00D0;
    n_beats = 0; last_c = -1; done_c = -1;
    for (int c = 0; c < 10; c++) begin
      samp();
      if (bus.phys_gnt) begin
        if (n_beats < 8) beat_addr[n_beats] = bus.address_dmem;
        n_beats++; last_c = c;
      end
      if (bus.phys_done) done_c = c;
      tick();
      if (n_beats > 0) bus.phys_req = 0;
      bus.phys_wdata = 32'h0000_00D0 + 32'(n_beats);
    end
    chk("wburst_beats", 32'(n_beats), 32'd4);
    chk("wburst_a0", {20'd0, beat_addr[0]}, 32'hFFE);
    chk("wburst_a1", {20'd0, beat_addr[1]}, 32'hFFF);
    chk("wburst_a2", {20'd0, beat_addr[2]}, 32'h000);
    chk("wburst_a3", {20'd0, beat_addr[3]}, 32'h001);
    chk("wburst_done_lat", 32'(done_c), 32'(last_c + 1));
    chk("wburst_mem_fff", mem_rd(12'hFFF), 32'h0000_00D1);
    chk("wburst_mem_001", mem_rd(12'h001), 32'h0000_00D3);
    idle_inputs();

    // contention right after reset: PHYS, then VGA, then PHYS
    reset = 0; tick(); reset = 1;
    bus.phys_req = 1; bus.phys_addr = 12'h020; bus.phys_len = 4'd0; bus.phys_wren = 0;
    bus.vga_req = 1; bus.vga_addr = 12'h030;
    samp();
    chk("tie1_phys", {30'd0, bus.phys_gnt, bus.vga_gnt}, 32'b10);
    tick();
    samp();
    chk("tie2_vga", {30'd0, bus.phys_gnt, bus.vga_gnt}, 32'b01);
    chk("tie2_done", {31'd0, bus.phys_done}, 32'd1);
    chk("tie2_prdata", bus.phys_rdata, 32'hA500_0020);
    tick();
    samp();
    chk("tie3_phys", {30'd0, bus.phys_gnt, bus.vga_gnt}, 32'b10);
    tick(); idle_inputs();
    tick();

    // read burst paused by the processor on cycles 2 and 3
    bus.phys_req = 1; bus.phys_addr = 12'h200; bus.phys_len = 4'd3; bus.phys_wren = 0;
    bus.proc_addr = 12'h050;
    n_beats = 0; n_rv = 0; n_done = 0;
    for (int c = 0; c < 10; c++) begin
      samp();
      if (bus.phys_gnt) n_beats++;
      if (bus.phys_rvalid) begin
        if (n_rv < 8) rd_data[n_rv] = bus.phys_rdata;
        n_rv++;
      end
      if (bus.phys_done) n_done++;
      if (c == 2) chk("preempt_proc_rdata", bus.proc_rdata, 32'hA500_0050);
      tick();
      if (n_beats > 0) bus.phys_req = 0;
      bus.proc_en = (c + 1 == 2) || (c + 1 == 3);
    end
    chk("rburst_beats", 32'(n_beats), 32'd4);
    chk("rburst_rvalids", 32'(n_rv), 32'd4);
    chk("rburst_d0", rd_data[0], 32'hA500_0200);
    chk("rburst_d1", rd_data[1], 32'hA500_0201);
    chk("rburst_d2", rd_data[2], 32'hA500_0202);
    chk("rburst_d3", rd_data[3], 32'hA500_0203);
    chk("rburst_done_once", 32'(n_done), 32'd1);
    idle_inputs();

    // processor hogging dmem while VGA waits
    bus.proc_en = 1; bus.proc_addr = 12'h060; bus.vga_req = 1; bus.vga_addr = 12'h070;
    for (int c = 0; c < 12; c++) begin
      samp();
`ifdef DMEM_ARB_STARVE_GUARD_EN
      chk("starve_stall", {31'd0, bus.proc_stall}, {31'd0, c == 8});
      chk("starve_vga_gnt", {31'd0, bus.vga_gnt}, {31'd0, c == 8});
`else
      chk("nostarve_stall", {31'd0, bus.proc_stall}, 32'd0);
      chk("nostarve_vga_gnt", {31'd0, bus.vga_gnt}, 32'd0);
`endif
      tick();
      if (c == 8) bus.vga_req = 0;
    end
    idle_inputs();
    tick();

    // reset in the middle of a write burst abandons it silently
    bus.phys_req = 1; bus.phys_addr = 12'h300; bus.phys_len = 4'd5; bus.phys_wren = 1;
    bus.phys_wdata = 32'h0000_00E0;
    samp(); tick(); bus.phys_req = 0; bus.phys_wdata = 32'h0000_00E1;
    samp(); tick();
    #2 reset = 0;
    samp();
    chk("midburst_rst_gnt", {31'd0, bus.phys_gnt}, 32'd0);
    tick(); tick(); reset = 1;
    n_done = 0; n_beats = 0;
    for (int c = 0; c < 4; c++) begin
      samp();
      if (bus.phys_done) n_done++;
      if (bus.phys_gnt) n_beats++;
      tick();
    end
    chk("midburst_no_done", 32'(n_done), 32'd0);
    chk("midburst_no_beats", 32'(n_beats), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem between three requesters:
  - the processor (highest priority),
  - the physics coprocessor (burst read/write),
  - the VGA sprite fetcher (single-word reads).
- Sits between these requesters and the dmem instance in skeleton; it owns address_dmem, data and wren.
- The processor path is combinational pass-through. Secondary requesters use req/gnt with a registered read return.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, dmem data width.
- BURST_W, 4, burst length field width; a burst moves len+1 words (max 16).
- STARVE_LIMIT, 8, consecutive processor-owned cycles with a secondary waiting before a forced processor stall (optional feature only).

Ports:
- clock  in  1  master clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- proc_en  in  1  processor issues a dmem access this cycle.
- proc_addr  in  ADDR_W  processor address.
- proc_wdata  in  DATA_W  processor write data.
- proc_wren  in  1  processor write enable.
- proc_rdata  out  DATA_W  q_dmem pass-through.
- proc_stall  out  1  processor must hold its memory stage this cycle.
- phys_req  in  1  physics burst request.
- phys_addr  in  ADDR_W  burst base address.
- phys_len  in  BURST_W  burst length minus one.
- phys_wren  in  1  burst direction: 1 = write.
- phys_wdata  in  DATA_W  write beat data.
- phys_gnt  out  1  a physics beat occurs this cycle.
- phys_rvalid  out  1  registered read beat valid.
- phys_rdata  out  DATA_W  registered read data.
- phys_done  out  1  one-cycle pulse after the last beat.
- vga_req  in  1  VGA read request.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  VGA access occurs this cycle.
- vga_rvalid  out  1  registered read valid.
- vga_rdata  out  DATA_W  registered read data.
- address_dmem  out  ADDR_W  to dmem.
- data  out  DATA_W  to dmem.
- wren  out  1  to dmem.
- q_dmem  in  DATA_W  from dmem; valid within the access cycle because dmem is clocked on ~clock.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; rr_ptr points to PHYS; beat counter and starve counter clear.
  - Every output except proc_rdata is 0 (address_dmem, data, wren, all gnt/rvalid/done, proc_stall, phys_rdata, vga_rdata).
  - Reset mid-burst abandons the burst with no phys_done.
- Owner per cycle:
  - The processor owns dmem when proc_en=1 and proc_stall=0.
  - Otherwise one secondary owns it, or nobody does (address_dmem=0, wren=0).
- FSM states:
  - IDLE, with a secondary free cycle:
    - If phys_req and vga_req are both pending, rr_ptr decides; rr_ptr then flips to the other requester.
    - If only one is pending, that one is granted.
    - VGA grant: a single beat (vga_gnt=1 for one cycle); state stays IDLE.
    - PHYS grant: latch base, len and dir; issue beat 0 in the same cycle; go to BURST (stay IDLE if len=0).
  - BURST:
    - Each free cycle issues beat k at address base+k, with phys_gnt=1 and wren=dir.
    - A processor access pauses the burst; the beat is not lost.
    - After beat len, return to IDLE; phys_done pulses on the next cycle.
    - VGA waits during a burst.
    - phys_req is ignored inside BURST.
- Address arithmetic: base+k wraps modulo 2^ADDR_W.
- Read return: rdata is registered from q_dmem at the clock edge ending the grant cycle; rvalid=1 the following cycle (latency 1).
- Gnt is combinational from current state and inputs; the requester must hold addr/wdata while req=1 and gnt=0.
- Writes never assert rvalid.
- Simultaneous processor access and burst completion: the completion is deferred until the last beat actually issues.

Optional Feature:
- Macro: DMEM_ARB_STARVE_GUARD_EN.
- Defined:
  - The starve counter increments each cycle the processor owns dmem while any secondary request (or unfinished burst) waits.
  - The counter clears on any secondary beat.
  - On reaching STARVE_LIMIT, proc_stall=1 for exactly one cycle, that cycle goes to the secondary, and the counter clears.
- Undefined: proc_stall is tied 0 and a secondary may starve indefinitely.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, BURST};
  - requester id constants PHYS=0, VGA=1;
  - default widths ADDR_W/DATA_W/BURST_W.
- One natural sub-module: dmem_arb_burst_ctr, holding the base/len latch, beat counter, address increment and last-beat flag.

Test Plan:
- Processor only: proc_en=1, proc_wren=1, addr 0x010, wdata 0xDEADBEEF -> address_dmem=0x010, wren=1, no gnt; a read of 0x010 returns 0xDEADBEEF on proc_rdata in the same cycle.
- VGA read with idle processor:
  - stimulus: vga_req, addr 0x100 holding 0x12345678;
  - response: vga_gnt the same cycle, then vga_rvalid=1 with vga_rdata=0x12345678 one cycle later.
- Physics write burst: base 0xFFE, len=3 -> beats to 0xFFE, 0xFFF, 0x000, 0x001 (wrap); four phys_gnt; phys_done one cycle after the last beat.
- Contention:
  - stimulus: phys_req and vga_req together from reset;
  - response: PHYS wins first (rr_ptr reset value); after its len=0 burst, VGA wins; the next tie goes to PHYS.
- Processor pre-emption: proc_en asserted on cycles 2 and 3 of a len=3 read burst -> the burst pauses and all 4 beats complete with correct data.
- Starvation, with DMEM_ARB_STARVE_GUARD_EN:
  - stimulus: proc_en held at 1 while vga_req is high;
  - response: proc_stall=1 on the 9th cycle (STARVE_LIMIT=8) and vga_gnt in that cycle.
  - Without the macro: proc_stall stays 0 and VGA is never granted.
